// File: rtl/turn_signal_sequencer_pkg.sv
// Shared types and constants for the turn signal sequencer.
// Contents: the state enum, the lamp pattern constants, the step counts
// per sequence, and the helper that maps a LEFT/RIGHT step to its lamps.
package tsig_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2,
        ST_HAZ   = 2'd3
    } state_e;

    localparam logic [2:0] P_OFF = 3'b000;
    localparam logic [2:0] P_1   = 3'b001;
    localparam logic [2:0] P_2   = 3'b011;
    localparam logic [2:0] P_3   = 3'b111;

    localparam int unsigned LR_STEPS  = 4;
    localparam int unsigned HAZ_STEPS = 2;

    // Bit 0 is the innermost lamp, so the chase grows outward.
    function automatic logic [2:0] lr_pattern(input logic [1:0] step);
        logic [2:0] p;
        case (step)
            2'd0:    p = P_1;
            2'd1:    p = P_2;
            2'd2:    p = P_3;
            default: p = P_OFF;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/turn_signal_sequencer_prescaler.sv
// tick_prescaler: clock-enable generator for the animation steps.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-low reset
//   en   - count enable; the counter is held at 0 while low
//   tick - registered one-cycle pulse in the cycle the count is TICK_DIV-1
module tick_prescaler #(
    parameter int TICK_DIV = 12_500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    always_comb begin
        cnt_d = '0;
        if (en) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
        end
        // Registered so that tick_q is high exactly while cnt_q == CNT_LAST.
        tick_d = en && (cnt_d == CNT_LAST);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/turn_signal_sequencer.sv
// turn_signal_sequencer: turns raw left/right/hazard switches into
// sequenced patterns on two 3-lamp tail clusters.
// Optional feature macro: TSIG_BRAKE_EN (adds the brk input and brake override).
// Ports:
//   clk  - system clock (single domain)
//   rst  - asynchronous active-low reset
//   l/r/h- left/right/hazard switches, asynchronous
//   brk  - brake switch, asynchronous (TSIG_BRAKE_EN only)
//   y    - left cluster lamps, bit 0 innermost (registered)
//   y2   - right cluster lamps, bit 0 innermost (registered)
//   busy - high while a sequence runs (registered)
//   tick - end-of-step pulse for debug (registered)
//
// state    | meaning
// ST_IDLE  | no sequence; arbitrate every cycle
// ST_LEFT  | left chase on y, 4 steps
// ST_RIGHT | right chase on y2, 4 steps
// ST_HAZ   | both clusters on then off, 2 steps
module turn_signal_sequencer
    import tsig_pkg::*;
#(
    parameter int TICK_DIV = 12_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       l,
    input  logic       r,
    input  logic       h,
`ifdef TSIG_BRAKE_EN
    input  logic       brk,
`endif
    output logic [2:0] y,
    output logic [2:0] y2,
    output logic       busy,
    output logic       tick
);

    // Synchronizers, bit order {h, r, l}.
    logic [2:0] sw_meta_q, sw_sync_q;
    logic       ls, rs, hs;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            sw_meta_q <= {h, r, l};
            sw_sync_q <= sw_meta_q;
        end
    end

    assign ls = sw_sync_q[0];
    assign rs = sw_sync_q[1];
    assign hs = sw_sync_q[2];

`ifdef TSIG_BRAKE_EN
    logic brk_meta_q, brk_sync_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            brk_meta_q <= 1'b0;
            brk_sync_q <= 1'b0;
        end else begin
            brk_meta_q <= brk;
            brk_sync_q <= brk_meta_q;
        end
    end
`endif

    state_e     state_q, state_d, winner;
    logic [1:0] step_q, step_d, last_step;
    logic [2:0] y_q, y_d, y2_q, y2_d;
    logic       busy_q, busy_d;
    logic       tick_w;

    tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .clk (clk),
        .rst (rst),
        .en  (state_q != ST_IDLE),
        .tick(tick_w)
    );

    always_comb begin
        if (hs || (ls && rs)) winner = ST_HAZ;
        else if (ls)          winner = ST_LEFT;
        else if (rs)          winner = ST_RIGHT;
        else                  winner = ST_IDLE;

        last_step = (state_q == ST_HAZ) ? 2'(HAZ_STEPS - 1) : 2'(LR_STEPS - 1);

        state_d = state_q;
        step_d  = step_q;
        if (state_q == ST_IDLE) begin
            state_d = winner;
            step_d  = 2'd0;
        end else if (tick_w) begin
            // Only the tick ending the last step re-arbitrates.
            if (step_q == last_step) begin
                state_d = winner;
                step_d  = 2'd0;
            end else begin
                step_d = step_q + 2'd1;
            end
        end

        // Lamps decode the next state so they land together with it.
        y_d  = P_OFF;
        y2_d = P_OFF;
        case (state_d)
            ST_LEFT:  y_d  = lr_pattern(step_d);
            ST_RIGHT: y2_d = lr_pattern(step_d);
            ST_HAZ: begin
                y_d  = (step_d == 2'd0) ? P_3 : P_OFF;
                y2_d = (step_d == 2'd0) ? P_3 : P_OFF;
            end
            default: ;
        endcase

`ifdef TSIG_BRAKE_EN
        if (brk_sync_q) begin
            case (state_d)
                ST_IDLE: begin
                    y_d  = P_3;
                    y2_d = P_3;
                end
                ST_LEFT:  y2_d = P_3;
                ST_RIGHT: y_d  = P_3;
                default: ;
            endcase
        end
`endif

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            step_q  <= 2'd0;
            y_q     <= P_OFF;
            y2_q    <= P_OFF;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            y_q     <= y_d;
            y2_q    <= y2_d;
            busy_q  <= busy_d;
        end
    end

    assign y    = y_q;
    assign y2   = y2_q;
    assign busy = busy_q;
    assign tick = tick_w;

endmodule

// File: tb/tb_turn_signal_sequencer.sv
module tb_turn_signal_sequencer;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       l = 1'b0, r = 1'b0, h = 1'b0;
`ifdef TSIG_BRAKE_EN
    logic       brk = 1'b0;
`endif
    logic [2:0] y, y2;
    logic       busy, tick;

    always #5 clk = ~clk;

    turn_signal_sequencer #(.TICK_DIV(DIV)) dut (
        .clk (clk),
        .rst (rst),
        .l   (l),
        .r   (r),
        .h   (h),
`ifdef TSIG_BRAKE_EN
        .brk (brk),
`endif
        .y   (y),
        .y2  (y2),
        .busy(busy),
        .tick(tick)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: mode 0 idle, 1 left, 2 right, 3 hazard; m_el counts
    // cycles since the current sequence started. Requests reach the decision
    // two edges after being sampled, modelled by the d1/d2 history.
    int         m_mode, m_el;
    logic [3:0] d1, d2;          // {brk, h, r, l}
    logic       m_brk;
    logic [2:0] e_y, e_y2;
    logic       e_busy, e_tick;

    function automatic logic [3:0] cur_inputs();
        logic b;
        b = 1'b0;
`ifdef TSIG_BRAKE_EN
        b = brk;
`endif
        return {b, h, r, l};
    endfunction

    function automatic int arb(logic [3:0] q);
        if (q[2] || (q[0] && q[1])) return 3;
        if (q[0]) return 1;
        if (q[1]) return 2;
        return 0;
    endfunction

    function automatic int seq_len(int mode);
        return (mode == 3) ? 2 * DIV : 4 * DIV;
    endfunction

    task automatic compute_exp();
        int step;
        logic [2:0] lamp;
        step = m_el / DIV;
        lamp = (step < 3) ? 3'((1 << (step + 1)) - 1) : 3'd0;
        e_y = 3'd0; e_y2 = 3'd0;
        if (m_mode == 1) e_y = lamp;
        if (m_mode == 2) e_y2 = lamp;
        if (m_mode == 3) begin
            e_y  = (step == 0) ? 3'b111 : 3'b000;
            e_y2 = e_y;
        end
        if (m_brk) begin
            if (m_mode == 0) begin e_y = 3'b111; e_y2 = 3'b111; end
            if (m_mode == 1) e_y2 = 3'b111;
            if (m_mode == 2) e_y  = 3'b111;
        end
        e_busy = (m_mode != 0);
        e_tick = (m_mode != 0) && ((m_el % DIV) == DIV - 1);
    endtask

    task automatic model_reset();
        m_mode = 0; m_el = 0; d1 = '0; d2 = '0; m_brk = 1'b0;
        compute_exp();
    endtask

    task automatic model_edge();
        logic [3:0] used;
        used = d2;
        d2   = d1;
        d1   = cur_inputs();
        if (m_mode == 0) begin
            m_mode = arb(used);
            m_el   = 0;
        end else begin
            m_el++;
            if (m_el == seq_len(m_mode)) begin
                m_mode = arb(used);
                m_el   = 0;
            end
        end
        m_brk = used[3];
        compute_exp();
    endtask

    // Inputs change only at negedge; outputs are sampled at the next negedge.
    task automatic advance();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        l = 1'b1;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({y, y2, busy, tick} !== 8'b0) begin
            n_fail++;
            $display("FAIL reset_hold: got y=%b y2=%b busy=%b tick=%b, want all 0", y, y2, busy, tick);
        end
        rst = 1'b1;
        model_reset();
        for (int i = 1; i <= 3; i++) begin
            advance();
            n_checks++;
            if (y !== ((i == 3) ? 3'b001 : 3'b000) || busy !== (i == 3)) begin
                n_fail++;
                $display("FAIL reset_release edge %0d: got y=%b busy=%b", i, y, busy);
            end
        end
    endtask

    task automatic test_left_held();
        int ticks;
        ticks = 0;
        for (int i = 0; i < 40; i++) begin
            advance();
            if (i >= 8) ticks += int'(tick);
            n_checks++;
            if ({y, y2, busy, tick} !== {e_y, e_y2, e_busy, e_tick}) begin
                n_fail++;
                $display("FAIL left_held cyc %0d: got y=%b y2=%b busy=%b tick=%b want y=%b y2=%b busy=%b tick=%b",
                         i, y, y2, busy, tick, e_y, e_y2, e_busy, e_tick);
            end
        end
        n_checks++;
        if (ticks !== 8) begin
            n_fail++;
            $display("FAIL left_tick_count: got %0d ticks in 32 cycles, want 8", ticks);
        end
    endtask

    task automatic test_left_release();
        int budget;
        budget = 0;
        while (!(m_mode == 1 && e_y == 3'b011) && budget < 40) begin
            advance();
            budget++;
        end
        n_checks++;
        if (budget >= 40) begin
            n_fail++;
            $display("FAIL left_release_wait: step 011 not reached, y=%b", y);
        end
        l = 1'b0;
        for (int i = 0; i < 24; i++) begin
            advance();
            n_checks++;
            if ({y, y2, busy, tick} !== {e_y, e_y2, e_busy, e_tick}) begin
                n_fail++;
                $display("FAIL left_release cyc %0d: got y=%b y2=%b busy=%b tick=%b want y=%b y2=%b busy=%b tick=%b",
                         i, y, y2, busy, tick, e_y, e_y2, e_busy, e_tick);
            end
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL left_release_idle: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_left_then_right();
        int budget;
        budget = 0;
        l = 1'b1;
        while (!(m_mode == 1 && e_y == 3'b111) && budget < 40) begin
            advance();
            budget++;
        end
        n_checks++;
        if (budget >= 40) begin
            n_fail++;
            $display("FAIL left_right_wait: step 111 not reached, y=%b", y);
        end
        l = 1'b0;
        r = 1'b1;
        for (int i = 0; i < 16; i++) begin
            advance();
            n_checks++;
            if ({y, y2, busy, tick} !== {e_y, e_y2, e_busy, e_tick}) begin
                n_fail++;
                $display("FAIL left_right cyc %0d: got y=%b y2=%b busy=%b tick=%b want y=%b y2=%b busy=%b tick=%b",
                         i, y, y2, busy, tick, e_y, e_y2, e_busy, e_tick);
            end
        end
        r = 1'b0;
        repeat (24) advance();
    endtask

    task automatic test_hazard_and_async_reset();
        l = 1'b1;
        r = 1'b1;
        for (int i = 0; i < 12; i++) begin
            advance();
            n_checks++;
            if ({y, y2, busy, tick} !== {e_y, e_y2, e_busy, e_tick}) begin
                n_fail++;
                $display("FAIL hazard cyc %0d: got y=%b y2=%b busy=%b tick=%b want y=%b y2=%b busy=%b tick=%b",
                         i, y, y2, busy, tick, e_y, e_y2, e_busy, e_tick);
            end
        end
        // Reset asserted between clock edges must clear outputs at once.
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({y, y2, busy, tick} !== 8'b0) begin
            n_fail++;
            $display("FAIL async_reset: got y=%b y2=%b busy=%b tick=%b, want all 0", y, y2, busy, tick);
        end
        l = 1'b0;
        r = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        advance();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) l = ~l;
            if ($urandom_range(0, 9) == 0) r = ~r;
            if ($urandom_range(0, 29) == 0) h = ~h;
`ifdef TSIG_BRAKE_EN
            if ($urandom_range(0, 14) == 0) brk = ~brk;
`endif
            advance();
            n_checks++;
            if ({y, y2, busy, tick} !== {e_y, e_y2, e_busy, e_tick}) begin
                n_fail++;
                $display("FAIL random cyc %0d: got y=%b y2=%b busy=%b tick=%b want y=%b y2=%b busy=%b tick=%b",
                         i, y, y2, busy, tick, e_y, e_y2, e_busy, e_tick);
            end
        end
        l = 1'b0; r = 1'b0; h = 1'b0;
`ifdef TSIG_BRAKE_EN
        brk = 1'b0;
`endif
        for (int i = 0; i < 24; i++) begin
            advance();
            n_checks++;
            if ({y, y2, busy, tick} !== {e_y, e_y2, e_busy, e_tick}) begin
                n_fail++;
                $display("FAIL random_drain cyc %0d: got y=%b y2=%b busy=%b tick=%b want y=%b y2=%b busy=%b tick=%b",
                         i, y, y2, busy, tick, e_y, e_y2, e_busy, e_tick);
            end
        end
    endtask

`ifdef TSIG_BRAKE_EN
    task automatic test_brake();
        brk = 1'b1;
        repeat (4) advance();
        n_checks++;
        if (y !== 3'b111 || y2 !== 3'b111 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL brake_idle: got y=%b y2=%b busy=%b want 111 111 0", y, y2, busy);
        end
        for (int phase = 0; phase < 2; phase++) begin
            if (phase == 0) l = 1'b1; else h = 1'b1;
            for (int i = 0; i < 20; i++) begin
                advance();
                n_checks++;
                if ({y, y2, busy, tick} !== {e_y, e_y2, e_busy, e_tick}) begin
                    n_fail++;
                    $display("FAIL brake phase %0d cyc %0d: got y=%b y2=%b busy=%b tick=%b want y=%b y2=%b busy=%b tick=%b",
                             phase, i, y, y2, busy, tick, e_y, e_y2, e_busy, e_tick);
                end
            end
            l = 1'b0;
            h = 1'b0;
            repeat (20) advance();
        end
        brk = 1'b0;
        repeat (4) advance();
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_left_held();
        test_left_release();
        test_left_then_right();
        test_hazard_and_async_reset();
`ifdef TSIG_BRAKE_EN
        test_brake();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
